countdown_timer: RTL and testbench
==================================

# countdown_timer

BCD countdown timer clocked by the board clock and advanced by the slow square wave from the clock divider. The divided clock is treated strictly as a data input: it is synchronized and edge-detected, never used as a clock. Each rising edge of the divided clock is one 0.1 s step at 10 Hz. The block exposes a seconds-tens / seconds-ones / tenths display value plus run/done status to the game control and display logic.

## Interface
- SYNC_STAGES, default 2: synchronizer flops on `tick_in` before edge detection; legal range 0..3.
- `clkin`  in  1  board clock; all flops on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick_in`  in  1  divided clock from the clock divider; only its rising edges matter.
- `start`  in  1  single-cycle pulse: run or resume.
- `pause`  in  1  single-cycle pulse: freeze counting.
- `clear`  in  1  single-cycle pulse: load `load_val` and return to IDLE.
- `load_val`  in  12  BCD value: [11:8] tens, [7:4] ones, [3:0] tenths.
- `digits`  out  12  current count, same BCD layout.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `expired`  out  1  one-cycle pulse on entry to DONE.

## Operation
- Tick path: `tick_in` passes through SYNC_STAGES flops, then an edge register. `tick_edge` = synced & ~edge_reg. All of these registers reset to 0.
- A `tick_in` held high produces exactly one `tick_edge`.
- Load clamp: any `load_val` nibble greater than 9 is loaded as 9.
- BCD decrement: tenths 0 borrows and becomes 9; ones 0 borrows and becomes 9; then tens decrements. Examples: 100 → 099, 010 → 009.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Priority within a cycle: `clear` > `pause` > `start` > `tick_edge`.
- `clear` in any state: counter ← clamp(`load_val`), next state IDLE. A `tick_edge` in the same cycle is dropped.
- IDLE + `start`:
  - counter ≠ 000: go to RUN.
  - counter = 000: go to DONE and pulse `expired`.
- IDLE ignores `tick_edge` and `pause`.
- RUN + `pause`: go to PAUSE. A `tick_edge` in the same cycle is dropped.
- RUN + `tick_edge`: decrement the counter. If the result is 000, go to DONE and assert `expired` on that same edge. `start` is ignored in RUN.
- PAUSE + `start`: go to RUN. PAUSE ignores `tick_edge`.
- DONE: counter holds 000 and `done` = 1. `start`, `pause` and ticks are ignored. Only `clear` or reset leaves DONE.
- Reset, including mid-run: state IDLE, counter 000, `running` = 0, `done` = 0, `expired` = 0, synchronizer and edge registers 0.
- A `tick_in` already high at reset release produces one edge. In IDLE that edge is harmless.

## Timing
- Define edge 1 as the first `clkin` edge that samples `tick_in` = 1. The counter update and `expired` become visible after clock edge SYNC_STAGES+1. With the default of 2, that is edge 3.
- Control pulses take effect on the edge that samples them. `digits`, `running` and `done` are registered and reflect the new state in the following cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `expired` is high for exactly one `clkin` cycle per entry to DONE.

## Structure
- Package `timer_pkg` holds:
  - `state_t` enum (IDLE, RUN, PAUSE, DONE);
  - `bcd_t` (4-bit digit);
  - constants BCD_MAX = 9 and ZERO_COUNT = 12'h000.
- Sub-module `bcd_digit_down`: one digit with borrow-in, borrow-out and a registered value. It is instantiated three times and chained tenths → ones → tens.

## Test plan
- Reset asserted mid-RUN at count 057 → all outputs 0 immediately, without waiting for a clock edge. After release, `start` goes to DONE because the counter is 000.
- Load 0x015, `clear`, `start`, then 15 `tick_in` edges → count sequence 014, 013 … 010, 009 … 000. `expired` pulses once on the 15th step, `done` = 1, and further ticks leave 000.
- Load 0x100, `clear`, `start`, one tick → 099. Load 0x010, one tick → 009.
- In RUN, assert `pause` in the cycle `tick_edge` fires → no decrement, state PAUSE. Three more ticks → no change. `start`, then one tick → one decrement.
- Load 0xFA3, `clear` → `digits` = 0x993. `tick_in` held high for 200 cycles → exactly one decrement to 0x992.
- SYNC_STAGES = 0 and 3 → decrement observed after clock edges 1 and 4 respectively, counted from the first edge sampling `tick_in` high.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t        BCD_MAX    = 4'd9;
  localparam logic [11:0] ZERO_COUNT = 12'h000;

  // Out-of-range nibbles load as the largest legal BCD digit.
  function automatic bcd_t clamp_bcd(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit: decrements on borrow-in, wraps 0 -> 9 and
// propagates the borrow to the next more significant digit.
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic clkin,
  input  logic rst_n,
  input  logic i_load,
  input  bcd_t i_load_val,
  input  logic i_borrow,
  output bcd_t o_value,
  output logic o_borrow
);

  bcd_t r_value;

  assign o_borrow = i_borrow && (r_value == 4'd0);
  assign o_value  = r_value;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= clamp_bcd(i_load_val);
    end else if (i_borrow) begin
      r_value <= (r_value == 4'd0) ? BCD_MAX : r_value - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// BCD countdown timer stepped by rising edges of a divided clock that is
// sampled as data, with IDLE/RUN/PAUSE/DONE control.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic [11:0] load_val,
  output logic [11:0] digits,
  output logic        running,
  output logic        done,
  output logic        expired
);

  logic [SYNC_STAGES:0] w_chain;
  logic                 r_edge;
  logic                 w_tick_edge;
  logic [11:0]          w_count;
  logic [3:0]           w_borrow;
  logic                 w_unused_borrow;
  logic                 w_dec;
  state_t               r_state;
  state_t               w_state_next;
  logic                 w_expired_next;
  logic                 r_running;
  logic                 r_done;
  logic                 r_expired;

  assign w_chain[0] = tick_in;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic r_q;
      always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= w_chain[gi];
      end
      assign w_chain[gi+1] = r_q;
    end
  endgenerate

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) r_edge <= 1'b0;
    else        r_edge <= w_chain[SYNC_STAGES];
  end

  assign w_tick_edge = w_chain[SYNC_STAGES] & ~r_edge;

  // Higher-priority pause/clear swallow a coincident tick.
  assign w_dec       = (r_state == RUN) && !clear && !pause && w_tick_edge;
  assign w_borrow[0] = w_dec;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      bcd_digit_down u_digit (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .i_load     (clear),
        .i_load_val (load_val[4*gi +: 4]),
        .i_borrow   (w_borrow[gi]),
        .o_value    (w_count[4*gi +: 4]),
        .o_borrow   (w_borrow[gi+1])
      );
    end
  endgenerate

  assign w_unused_borrow = w_borrow[3];

  always_comb begin
    w_state_next   = r_state;
    w_expired_next = 1'b0;
    if (clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_count == ZERO_COUNT) begin
              w_state_next   = DONE;
              w_expired_next = 1'b1;
            end else begin
              w_state_next = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            w_state_next = PAUSE;
          end else if (w_tick_edge && (w_count == 12'h001)) begin
            w_state_next   = DONE;
            w_expired_next = 1'b1;
          end
        end
        PAUSE: if (start) w_state_next = RUN;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == RUN);
      r_done    <= (w_state_next == DONE);
      r_expired <= w_expired_next;
    end
  end

  assign digits  = w_count;
  assign running = r_running;
  assign done    = r_done;
  assign expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: default sync depth plus 0 and 3
// stage instances for latency checks.
module tb_countdown_timer;

  logic        clkin = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] load_val = 12'h000;

  logic [11:0] digits2, digits0, digits3;
  logic        running2, running0, running3;
  logic        done2, done0, done3;
  logic        expired2, expired0, expired3;

  always #5 clkin = ~clkin;

  countdown_timer u_dut (
    .clkin(clkin), .rst_n(rst_n), .tick_in(tick_in), .start(start),
    .pause(pause), .clear(clear), .load_val(load_val), .digits(digits2),
    .running(running2), .done(done2), .expired(expired2)
  );

  countdown_timer #(.SYNC_STAGES(0)) u_s0 (
    .clkin(clkin), .rst_n(rst_n), .tick_in(tick_in), .start(start),
    .pause(pause), .clear(clear), .load_val(load_val), .digits(digits0),
    .running(running0), .done(done0), .expired(expired0)
  );

  countdown_timer #(.SYNC_STAGES(3)) u_s3 (
    .clkin(clkin), .rst_n(rst_n), .tick_in(tick_in), .start(start),
    .pause(pause), .clear(clear), .load_val(load_val), .digits(digits3),
    .running(running3), .done(done3), .expired(expired3)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_exp    = 0;
  int n_exp_model = 0;

  logic [11:0] m_digits = 12'h000;
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  logic [11:0] sb_q[$];

  always @(negedge clkin) if (expired2 === 1'b1) n_exp++;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("check %s: got %0h ok", tag, act);
    end
  endtask

  function automatic logic [11:0] model_dec(input logic [11:0] v);
    int n;
    logic [11:0] r;
    n = v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    if (n > 0) n--;
    r[11:8] = 4'(n / 100);
    r[7:4]  = 4'((n / 10) % 10);
    r[3:0]  = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [11:0] model_clamp(input logic [11:0] v);
    logic [11:0] r;
    for (int k = 0; k < 3; k++) begin
      logic [3:0] d;
      d = v[4*k +: 4];
      r[4*k +: 4] = (d > 4'd9) ? 4'd9 : d;
    end
    return r;
  endfunction

  task automatic pop_check(input string tag);
    logic [11:0] e;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val(tag, digits2, e);
    end
  endtask

  task automatic do_clear(input logic [11:0] v);
    @(negedge clkin); load_val = v; clear = 1'b1;
    @(negedge clkin); clear = 1'b0;
    m_digits = model_clamp(v); m_run = 1'b0; m_done = 1'b0;
    sb_q.push_back(m_digits);
    pop_check("clear_load");
  endtask

  task automatic do_start();
    @(negedge clkin); start = 1'b1;
    @(negedge clkin); start = 1'b0;
    if (!m_run && !m_done) begin
      if (m_digits == 12'h000) begin m_done = 1'b1; n_exp_model++; end
      else m_run = 1'b1;
    end
    @(negedge clkin);
    check_val("start_running", running2, m_run);
    check_val("start_done", done2, m_done);
  endtask

  task automatic do_tick(input string tag);
    @(negedge clkin); tick_in = 1'b1;
    @(negedge clkin); tick_in = 1'b0;
    if (m_run) begin
      m_digits = model_dec(m_digits);
      if (m_digits == 12'h000) begin m_run = 1'b0; m_done = 1'b1; n_exp_model++; end
    end
    sb_q.push_back(m_digits);
    repeat (5) @(negedge clkin);
    pop_check(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_val("reset_digits", {digits0, digits2, digits3}, 36'h0);
    check_val("reset_flags", {running2, done2, expired2}, 3'b000);
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a run.
    do_clear(12'h057);
    do_start();
    @(negedge clkin); #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_digits", digits2, 12'h000);
    check_val("rst_mid_flags", {running2, done2, expired2}, 3'b000);
    @(negedge clkin); rst_n = 1'b1;
    m_digits = 12'h000; m_run = 1'b0; m_done = 1'b0;
    do_start();
    check_val("zero_start_exp", n_exp, n_exp_model);

    // Count 015 down to 000 across both digit borrows.
    do_clear(12'h015);
    do_start();
    for (int i = 1; i <= 15; i++) begin
      do_tick($sformatf("step015_%0d", i));
      if (i == 14) check_val("exp_before_end", n_exp, n_exp_model);
    end
    check_val("end_exp_once", n_exp, n_exp_model);
    check_val("end_flags", {running2, done2}, 2'b01);
    do_tick("done_hold_a");
    do_tick("done_hold_b");
    check_val("done_no_reexp", n_exp, n_exp_model);

    do_clear(12'h100); do_start(); do_tick("borrow_100");
    do_clear(12'h010); do_start(); do_tick("borrow_010");

    // Pause arriving in the same cycle as the tick edge wins.
    do_clear(12'h050); do_start();
    @(negedge clkin); tick_in = 1'b1;
    @(negedge clkin); tick_in = 1'b0;
    @(negedge clkin); pause = 1'b1;
    @(negedge clkin); pause = 1'b0;
    m_run = 1'b0;
    repeat (4) @(negedge clkin);
    sb_q.push_back(m_digits);
    pop_check("pause_collide");
    check_val("pause_running", running2, 1'b0);
    for (int i = 0; i < 3; i++) do_tick($sformatf("paused_tick_%0d", i));
    do_start();
    do_tick("resume_tick");

    // Clamped load, then a long-held tick gives a single step.
    do_clear(12'hFA3);
    do_start();
    @(negedge clkin); tick_in = 1'b1;
    repeat (200) @(negedge clkin);
    tick_in = 1'b0;
    m_digits = model_dec(m_digits);
    sb_q.push_back(m_digits);
    repeat (6) @(negedge clkin);
    pop_check("held_tick");

    // Latency from the first edge sampling tick_in high.
    do_clear(12'h020);
    do_start();
    @(negedge clkin); tick_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clkin);
      if (k == 1) tick_in = 1'b0;
      check_val($sformatf("lat_s0_e%0d", k), digits0, 12'h019);
      check_val($sformatf("lat_s2_e%0d", k), digits2, (k >= 3) ? 12'h019 : 12'h020);
      check_val($sformatf("lat_s3_e%0d", k), digits3, (k >= 4) ? 12'h019 : 12'h020);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
